// File: rtl/placement_pkg.sv
// Strip geometry, region constants and FSM encoding shared by the placement controller.
package placement_pkg;

    localparam int NUM_STRIPS = 13;
    localparam int REGION_W   = 128;
    localparam logic [7:0] STRIKE_COORD = 8'd128;

    localparam logic [7:0] STRIP_YOFF [1:13] = '{
        8'd0,  8'd8,  8'd16, 8'd25, 8'd32, 8'd42, 8'd48,
        8'd59, 8'd64, 8'd76, 8'd80, 8'd96, 8'd112
    };

    localparam logic [4:0] STRIP_H [1:13] = '{
        5'd8,  5'd8,  5'd9,  5'd7,  5'd10, 5'd6,  5'd11,
        5'd5,  5'd12, 5'd4,  5'd16, 5'd16, 5'd16
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        COMMIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Range-safe lookups: ids outside 1..13 read as zero.
    function automatic logic [4:0] strip_h_of(input logic [3:0] id);
        strip_h_of = '0;
        for (int i = 1; i <= NUM_STRIPS; i++) begin
            if (id == 4'(i)) strip_h_of = STRIP_H[i];
        end
    endfunction

    function automatic logic [7:0] strip_yoff_of(input logic [3:0] id);
        strip_yoff_of = '0;
        for (int i = 1; i <= NUM_STRIPS; i++) begin
            if (id == 4'(i)) strip_yoff_of = STRIP_YOFF[i];
        end
    endfunction

endpackage

// File: rtl/strip_occupancy.sv
// Per-strip occupied-width registers: one comb read port, one write port, sync clear-all.
// Zero latency on read; writes land on the next edge; no backpressure.
module strip_occupancy
    import placement_pkg::*;
#(
    parameter int NUM = NUM_STRIPS,
    parameter int AW  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_dat,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_dat,
    input  logic          i_clr
);

    logic [7:0] r_occ [1:NUM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= NUM; i++) r_occ[i] <= '0;
        end else if (i_clr) begin
            for (int i = 1; i <= NUM; i++) r_occ[i] <= '0;
        end else if (i_wr_en) begin
            for (int i = 1; i <= NUM; i++) begin
                if (i_wr_addr == AW'(i)) r_occ[i] <= i_wr_dat;
            end
        end
    end

    always_comb begin
        o_rd_dat = '0;
        for (int i = 1; i <= NUM; i++) begin
            if (i_rd_addr == AW'(i)) o_rd_dat = r_occ[i];
        end
    end

endmodule

// File: rtl/placement_ctrl.sv
// Best-fit strip placement: one request at a time, 15 cycles handshake-to-response.
// Accepts only in IDLE; result held stable in RESP until resp_ready_in.
module placement_ctrl #(
    parameter int NUM_STRIPS = placement_pkg::NUM_STRIPS,
    parameter int REGION_W   = placement_pkg::REGION_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid_in,
    output logic       req_ready_out,
    input  logic [7:0] req_width_in,
    input  logic [4:0] req_height_in,
    input  logic       clear_in,
    output logic       resp_valid_out,
    input  logic       resp_ready_in,
    output logic [7:0] x_out,
    output logic [7:0] y_out,
    output logic       strike_flag_out,
    output logic [3:0] strike_count_out
);

    import placement_pkg::*;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_req_w;
    logic [4:0] r_req_h;
    logic [3:0] r_k;
    logic [3:0] r_best_id;
    logic [4:0] r_best_h;
    logic [7:0] r_best_x;
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic       r_strike;
    logic [3:0] r_strike_cnt;

    logic       w_idle;
    logic       w_search;
    logic       w_commit;
    logic       w_resp;
    logic       w_hs;
    logic       w_clr;
    logic       w_last;
    logic       w_legal;
    logic       w_fit;
    logic       w_better;
    logic       w_place;
    logic [7:0] w_occ_rd;
    logic [4:0] w_k_h;
    logic [8:0] w_sum;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (req_valid_in) w_state_nxt = SEARCH;
            SEARCH:  if (w_last)       w_state_nxt = COMMIT;
            COMMIT:                    w_state_nxt = RESP;
            RESP:    if (resp_ready_in) w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    // State decode outputs
    always_comb begin
        w_idle   = 1'b0;
        w_search = 1'b0;
        w_commit = 1'b0;
        w_resp   = 1'b0;
        unique case (r_state)
            IDLE:    w_idle   = 1'b1;
            SEARCH:  w_search = 1'b1;
            COMMIT:  w_commit = 1'b1;
            RESP:    w_resp   = 1'b1;
            default: w_idle   = 1'b1;
        endcase
    end

    assign req_ready_out  = w_idle;
    assign resp_valid_out = w_resp;
    assign w_hs   = w_idle & req_valid_in;
    // A handshake in the same cycle swallows the clear.
    assign w_clr  = w_idle & clear_in & ~req_valid_in;
    assign w_last = (r_k == 4'(NUM_STRIPS));

    // Fit comparator for the strip currently addressed by r_k
    assign w_k_h   = strip_h_of(r_k);
    assign w_sum   = {1'b0, w_occ_rd} + {1'b0, r_req_w};
    assign w_legal = (r_req_w != 8'd0) && (r_req_w <= 8'(REGION_W)) &&
                     (r_req_h != 5'd0) && (r_req_h <= 5'd16);
    assign w_fit   = w_legal && (w_k_h >= r_req_h) && (w_sum <= 9'(REGION_W));
    // Strict less-than keeps the lower id on equal heights since k scans upward.
    assign w_better = w_fit && ((r_best_id == 4'd0) || (w_k_h < r_best_h));
    assign w_place  = (r_best_id != 4'd0);

    strip_occupancy #(
        .NUM (NUM_STRIPS),
        .AW  (4)
    ) u_occ (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rd_addr (r_k),
        .o_rd_dat  (w_occ_rd),
        .i_wr_en   (w_commit & w_place),
        .i_wr_addr (r_best_id),
        .i_wr_dat  (r_best_x + r_req_w),
        .i_clr     (w_clr)
    );

    // Request latch and candidate scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_w   <= '0;
            r_req_h   <= '0;
            r_k       <= 4'd1;
            r_best_id <= '0;
            r_best_h  <= '0;
            r_best_x  <= '0;
        end else if (w_hs) begin
            r_req_w   <= req_width_in;
            r_req_h   <= req_height_in;
            r_k       <= 4'd1;
            r_best_id <= '0;
            r_best_h  <= '0;
            r_best_x  <= '0;
        end else if (w_search) begin
            if (w_better) begin
                r_best_id <= r_k;
                r_best_h  <= w_k_h;
                r_best_x  <= w_occ_rd;
            end
            if (!w_last) r_k <= r_k + 4'd1;
        end
    end

    // Result registers and strike counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_strike     <= 1'b0;
            r_strike_cnt <= '0;
        end else if (w_commit) begin
            if (w_place) begin
                r_x      <= r_best_x;
                r_y      <= strip_yoff_of(r_best_id);
                r_strike <= 1'b0;
            end else begin
                r_x      <= 8'(REGION_W);
                r_y      <= 8'(REGION_W);
                r_strike <= 1'b1;
                if (r_strike_cnt != 4'hF) r_strike_cnt <= r_strike_cnt + 4'd1;
            end
        end else if (w_clr) begin
            r_strike_cnt <= '0;
        end
    end

    assign x_out            = r_x;
    assign y_out            = r_y;
    assign strike_flag_out  = r_strike;
    assign strike_count_out = r_strike_cnt;

endmodule

// File: tb/tb_placement_ctrl.sv
// Scoreboard bench for placement_ctrl: reference best-fit model queues expected results per request.
module tb_placement_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid_in;
    logic       req_ready_out;
    logic [7:0] req_width_in;
    logic [4:0] req_height_in;
    logic       clear_in;
    logic       resp_valid_out;
    logic       resp_ready_in;
    logic [7:0] x_out;
    logic [7:0] y_out;
    logic       strike_flag_out;
    logic [3:0] strike_count_out;

    placement_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_in     (req_valid_in),
        .req_ready_out    (req_ready_out),
        .req_width_in     (req_width_in),
        .req_height_in    (req_height_in),
        .clear_in         (clear_in),
        .resp_valid_out   (resp_valid_out),
        .resp_ready_in    (resp_ready_in),
        .x_out            (x_out),
        .y_out            (y_out),
        .strike_flag_out  (strike_flag_out),
        .strike_count_out (strike_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int TB_YOFF [1:13] = '{0, 8, 16, 25, 32, 42, 48, 59, 64, 76, 80, 96, 112};
    localparam int TB_H    [1:13] = '{8, 8, 9, 7, 10, 6, 11, 5, 12, 4, 16, 16, 16};

    typedef struct {
        int x;
        int y;
        int strike;
        int cnt;
    } exp_t;

    exp_t sb [$];
    int   m_occ [1:13];
    int   m_cnt;
    int   n_checks;
    int   n_errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 1; k <= 13; k++) m_occ[k] = 0;
        m_cnt = 0;
    endtask

    task automatic model_push(input int w, input int h);
        exp_t e;
        int   best;
        best = 0;
        if (w >= 1 && w <= 128 && h >= 1 && h <= 16) begin
            for (int k = 1; k <= 13; k++) begin
                if (TB_H[k] >= h && m_occ[k] + w <= 128) begin
                    if (best == 0 || TB_H[k] < TB_H[best]) best = k;
                end
            end
        end
        if (best != 0) begin
            e.x = m_occ[best];
            e.y = TB_YOFF[best];
            e.strike = 0;
            m_occ[best] += w;
        end else begin
            e.x = 128;
            e.y = 128;
            e.strike = 1;
            if (m_cnt < 15) m_cnt++;
        end
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    // Called at a negedge while the DUT is idle; returns at a negedge with the DUT idle again.
    task automatic do_req(input int w, input int h, input bit clr, input int bp);
        int         n;
        int         lat;
        exp_t       e;
        logic [7:0] hx;
        logic [7:0] hy;
        n = 0;
        while (!req_ready_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", req_ready_out, 1);
        req_valid_in  = 1'b1;
        req_width_in  = 8'(w);
        req_height_in = 5'(h);
        clear_in      = clr;
        resp_ready_in = (bp == 0);
        model_push(w, h);
        @(negedge clk);
        req_valid_in = 1'b0;
        clear_in     = 1'b0;
        check("ready_low_search", req_ready_out, 0);
        lat = 1;
        while (!resp_valid_out && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 15);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("x", x_out, e.x);
            check("y", y_out, e.y);
            check("strike", strike_flag_out, e.strike);
            check("strike_cnt", strike_count_out, e.cnt);
        end
        hx = x_out;
        hy = y_out;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_valid", resp_valid_out, 1);
            check("bp_x_stable", x_out, hx);
            check("bp_y_stable", y_out, hy);
            check("bp_no_ready", req_ready_out, 0);
        end
        resp_ready_in = 1'b1;
        @(negedge clk);
        check("ready_after_resp", req_ready_out, 1);
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp_valid"}, resp_valid_out, 0);
        check({tag, "_x"}, x_out, 0);
        check({tag, "_y"}, y_out, 0);
        check({tag, "_strike"}, strike_flag_out, 0);
        check({tag, "_cnt"}, strike_count_out, 0);
        check({tag, "_ready"}, req_ready_out, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        req_valid_in  = 1'b0;
        req_width_in  = '0;
        req_height_in = '0;
        clear_in      = 1'b0;
        resp_ready_in = 1'b1;
        model_reset();

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", req_ready_out, 1);

        // Tie on height resolved to lowest id, then spill into strip 2
        do_req(10, 8, 1'b0, 0);
        do_req(120, 8, 1'b0, 0);
        // Tightest height wins
        do_req(20, 5, 1'b0, 0);
        do_req(20, 5, 1'b0, 0);
        // Exhaust the tall strips, then strike, then illegal width
        for (int i = 0; i < 4; i++) do_req(128, 16, 1'b0, 0);
        do_req(0, 5, 1'b0, 0);
        do_req(129, 5, 1'b0, 0);
        do_req(5, 17, 1'b0, 0);
        // Backpressure
        do_req(5, 4, 1'b0, 5);
        // Clear in idle, then clear coincident with a handshake
        do_clear();
        do_req(128, 16, 1'b0, 0);
        do_req(128, 16, 1'b1, 0);
        do_req(128, 16, 1'b0, 0);

        // Reset in the middle of SEARCH
        req_valid_in  = 1'b1;
        req_width_in  = 8'd30;
        req_height_in = 5'd3;
        @(negedge clk);
        req_valid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midsearch_no_resp", resp_valid_out, 0);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(30, 3, 1'b0, 0);

        // Drive the strike counter into saturation
        for (int i = 0; i < 16; i++) do_req(10, 0, 1'b0, 0);
        do_clear();

        // Random traffic against the model
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 9) == 0) do_clear();
            do_req($urandom_range(0, 140), $urandom_range(0, 18), 1'b0, $urandom_range(0, 2));
        end

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
